// File: rtl/cv_tile_scheduler.sv
// ---------------------------------------------------------------------------
// cv_tile_scheduler
//   Walks one convolution layer tile by tile and sequences the data loader
//   and the compute core for every tile. Output-channel tiles are outermost,
//   then input-tile rows, then input-tile columns. Weights are reloaded once
//   per output-channel tile; the input tile is reloaded for every spatial tile.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a layer (only looked at in IDLE)
//   I, O, H, W, K   : layer shape (in/out channels, input height/width, kernel)
//   loader_done     : one-cycle completion pulse from the loader
//   core_calc_done  : level from the compute core, tile finished
//   load_weight, load_input, store_output : one-cycle loader requests
//   core_start      : one-cycle compute kick
//   Oori/Oext, Hori/Hext, Wori/Wext : current tile origin and extent
//   busy            : high outside IDLE
//   done            : one-cycle end-of-layer pulse
//   err             : sticky configuration error (cleared by a valid start)
//
// Handshake: every request is a one-cycle pulse issued from its *_REQ state;
// the matching loader_done is accepted only in the following *_WAIT state,
// including the very first cycle of that state. Tile origin/extent outputs
// are registers that only change on layer start and in NEXT, so they are
// stable for the whole request/wait window.
// ---------------------------------------------------------------------------
module cv_tile_scheduler #(
   parameter int TO_MAX = 16,
   parameter int TH_MAX = 16,
   parameter int TW_MAX = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] I,
   input  logic [10:0] O,
   input  logic [10:0] H,
   input  logic [10:0] W,
   input  logic [4:0]  K,
   input  logic        loader_done,
   input  logic        core_calc_done,
   output logic        load_weight,
   output logic        load_input,
   output logic        store_output,
   output logic        core_start,
   output logic [10:0] Oori,
   output logic [10:0] Oext,
   output logic [7:0]  Hori,
   output logic [7:0]  Wori,
   output logic [7:0]  Hext,
   output logic [7:0]  Wext,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      IDLE, LW_REQ, LW_WAIT, LIF_REQ, LIF_WAIT, CALC, SOF_REQ, SOF_WAIT, NEXT, DONE
   } state_t;

   localparam logic [11:0] TO12 = 12'(TO_MAX);
   localparam logic [11:0] TH12 = 12'(TH_MAX);
   localparam logic [11:0] TW12 = 12'(TW_MAX);

   state_t      state, state_n;
   logic        calc_started;   // kick already issued in the current CALC visit
   logic        upd;            // load origin/extent registers this cycle
   logic        cfg_err;
   logic [11:0] k12, h12, w12, o12;
   logic [11:0] hout, wout, sh, sw;
   logic [11:0] w_adv, h_adv, o_adv;
   logic [11:0] n_oori, n_hori, n_wori;
   logic [11:0] o_rem, h_rem, w_rem;
   logic [11:0] n_oext, n_hext, n_wext;

   // All shape arithmetic is carried at 12 bits and truncated on register load.
   assign k12 = {7'd0, K};
   assign h12 = {1'b0, H};
   assign w12 = {1'b0, W};
   assign o12 = {1'b0, O};

   assign hout = h12 - k12 + 12'd1;
   assign wout = w12 - k12 + 12'd1;
   assign sh   = TH12 - k12 + 12'd1;
   assign sw   = TW12 - k12 + 12'd1;

   assign w_adv = {4'd0, Wori} + sw;
   assign h_adv = {4'd0, Hori} + sh;
   assign o_adv = {1'b0, Oori} + TO12;

   assign cfg_err = (K == 5'd0) || (O == 11'd0) || (I == 11'd0) ||
                    (k12 > h12) || (k12 > w12) || (k12 > TH12) || (k12 > TW12);

   // Extents follow the origins that are about to be loaded.
   assign o_rem  = o12 - n_oori;
   assign h_rem  = h12 - n_hori;
   assign w_rem  = w12 - n_wori;
   assign n_oext = (o_rem > TO12) ? TO12 : o_rem;
   assign n_hext = (h_rem > TH12) ? TH12 : h_rem;
   assign n_wext = (w_rem > TW12) ? TW12 : w_rem;

   always_comb begin
      state_n = state;
      upd     = 1'b0;
      n_oori  = {1'b0, Oori};
      n_hori  = {4'd0, Hori};
      n_wori  = {4'd0, Wori};
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_err) begin
                  state_n = DONE;
               end else begin
                  state_n = LW_REQ;
                  upd     = 1'b1;
                  n_oori  = 12'd0;
                  n_hori  = 12'd0;
                  n_wori  = 12'd0;
               end
            end
         end
         LW_REQ:   state_n = LW_WAIT;
         LW_WAIT:  if (loader_done) state_n = LIF_REQ;
         LIF_REQ:  state_n = LIF_WAIT;
         LIF_WAIT: if (loader_done) state_n = CALC;
         // The done level may still be high from the previous tile, so it is
         // only honoured once the kick cycle is over.
         CALC:     if (calc_started && core_calc_done) state_n = SOF_REQ;
         SOF_REQ:  state_n = SOF_WAIT;
         SOF_WAIT: if (loader_done) state_n = NEXT;
         NEXT: begin
            upd = 1'b1;
            if (w_adv < wout) begin
               n_wori  = w_adv;
               state_n = LIF_REQ;
            end else begin
               n_wori = 12'd0;
               if (h_adv < hout) begin
                  n_hori  = h_adv;
                  state_n = LIF_REQ;
               end else begin
                  n_hori = 12'd0;
                  if (o_adv < o12) begin
                     n_oori  = o_adv;
                     state_n = LW_REQ;
                  end else begin
                     // Last tile: keep the final tile's origins on the outputs.
                     upd     = 1'b0;
                     state_n = DONE;
                  end
               end
            end
         end
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         calc_started <= 1'b0;
         err          <= 1'b0;
         Oori         <= '0;
         Oext         <= '0;
         Hori         <= '0;
         Hext         <= '0;
         Wori         <= '0;
         Wext         <= '0;
      end else begin
         state        <= state_n;
         calc_started <= (state == CALC);
         if (state == IDLE && start) err <= cfg_err;
         if (upd) begin
            Oori <= n_oori[10:0];
            Oext <= n_oext[10:0];
            Hori <= n_hori[7:0];
            Hext <= n_hext[7:0];
            Wori <= n_wori[7:0];
            Wext <= n_wext[7:0];
         end
      end
   end

   assign load_weight  = (state == LW_REQ);
   assign load_input   = (state == LIF_REQ);
   assign store_output = (state == SOF_REQ);
   assign core_start   = (state == CALC) && !calc_started;
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

endmodule

// File: tb/tb_cv_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cv_tile_scheduler
//   Directed bench for cv_tile_scheduler. A loader model answers every
//   request with a loader_done pulse after a random delay, a core model
//   answers core_start with a core_calc_done level after a random delay.
//   Each layer start pushes the full expected event list (requests with
//   their tile coordinates, then done/err) into exp_q; a negedge monitor
//   pops and compares every event the DUT emits.
// ---------------------------------------------------------------------------
module tb_cv_tile_scheduler;

   localparam int TO_MAX = 16;
   localparam int TH_MAX = 16;
   localparam int TW_MAX = 16;
   localparam int EW     = 57;

   localparam logic [2:0] EV_LW = 3'd1;
   localparam logic [2:0] EV_LI = 3'd2;
   localparam logic [2:0] EV_CS = 3'd3;
   localparam logic [2:0] EV_SO = 3'd4;
   localparam logic [2:0] EV_DN = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        start = 1'b0;
   logic [10:0] i_ch = '0, o_ch = '0, h_in = '0, w_in = '0;
   logic [4:0]  k_in = '0;
   logic        loader_done_r = 1'b0;
   logic        spurious_ld = 1'b0;
   logic        loader_done;
   logic        core_calc_done = 1'b0;
   logic        load_weight, load_input, store_output, core_start;
   logic [10:0] Oori, Oext;
   logic [7:0]  Hori, Wori, Hext, Wext;
   logic        busy, done, err;

   assign loader_done = loader_done_r | spurious_ld;

   cv_tile_scheduler #(.TO_MAX(TO_MAX), .TH_MAX(TH_MAX), .TW_MAX(TW_MAX)) dut (
      .clk(clk), .rst(rst), .start(start),
      .I(i_ch), .O(o_ch), .H(h_in), .W(w_in), .K(k_in),
      .loader_done(loader_done), .core_calc_done(core_calc_done),
      .load_weight(load_weight), .load_input(load_input),
      .store_output(store_output), .core_start(core_start),
      .Oori(Oori), .Oext(Oext), .Hori(Hori), .Wori(Wori),
      .Hext(Hext), .Wext(Wext), .busy(busy), .done(done), .err(err)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];
   int n_lw = 0, n_li = 0, n_cs = 0, n_so = 0, n_dn = 0;
   bit slow_core = 1'b0;
   logic [EW-1:0] mon_obs;
   bit mon_ev;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [EW-1:0] mk(input logic [2:0] t, input int oo, input int oe,
                                        input int hh, input int he, input int ww, input int we);
      return {t, 11'(oo), 11'(oe), 8'(hh), 8'(he), 8'(ww), 8'(we)};
   endfunction

   // Reference walk of the layer: plain nested loops over tile origins.
   task automatic push_model(input int o, input int h, input int w, input int k, input bit err_exp);
      int hout, wout, sh, sw, oext, hext, wext;
      if (!err_exp) begin
         hout = h - k + 1;
         wout = w - k + 1;
         sh   = TH_MAX - k + 1;
         sw   = TW_MAX - k + 1;
         for (int oo = 0; oo < o; oo += TO_MAX) begin
            oext = imin(TO_MAX, o - oo);
            exp_q.push_back(mk(EV_LW, oo, oext, 0, imin(TH_MAX, h), 0, imin(TW_MAX, w)));
            for (int hh = 0; hh < hout; hh += sh) begin
               hext = imin(TH_MAX, h - hh);
               for (int ww = 0; ww < wout; ww += sw) begin
                  wext = imin(TW_MAX, w - ww);
                  exp_q.push_back(mk(EV_LI, oo, oext, hh, hext, ww, wext));
                  exp_q.push_back(mk(EV_CS, oo, oext, hh, hext, ww, wext));
                  exp_q.push_back(mk(EV_SO, oo, oext, hh, hext, ww, wext));
               end
            end
         end
      end
      exp_q.push_back({EV_DN, 53'd0, err_exp});
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      mon_ev = 1'b1;
      if (load_weight) begin
         mon_obs = {EV_LW, Oori, Oext, Hori, Hext, Wori, Wext}; n_lw++;
      end else if (load_input) begin
         mon_obs = {EV_LI, Oori, Oext, Hori, Hext, Wori, Wext}; n_li++;
      end else if (core_start) begin
         mon_obs = {EV_CS, Oori, Oext, Hori, Hext, Wori, Wext}; n_cs++;
      end else if (store_output) begin
         mon_obs = {EV_SO, Oori, Oext, Hori, Hext, Wori, Wext}; n_so++;
      end else if (done) begin
         mon_obs = {EV_DN, 53'd0, err}; n_dn++;
      end else begin
         mon_ev = 1'b0;
      end
      if (mon_ev) begin
         if (exp_q.size() == 0) check("sb_unexpected_event", exp_q.size(), 1);
         else check("sb_event", mon_obs, exp_q.pop_front());
      end
   end

   // ---------------- loader model ----------------
   initial begin
      forever begin
         @(negedge clk);
         loader_done_r = 1'b0;
         if (load_weight || load_input || store_output) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            loader_done_r = 1'b1;
         end
      end
   end

   // ---------------- core model ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (core_start) begin
            core_calc_done = 1'b0;
            repeat (slow_core ? 50 : $urandom_range(0, 3)) @(negedge clk);
            core_calc_done = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_lw = 0; n_li = 0; n_cs = 0; n_so = 0; n_dn = 0;
   endtask

   task automatic start_layer(input int o, input int h, input int w, input int k,
                              input int i, input bit err_exp);
      o_ch = 11'(o); h_in = 11'(h); w_in = 11'(w); k_in = 5'(k); i_ch = 11'(i);
      push_model(o, h, w, k, err_exp);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 5000) begin
         tick();
         n++;
      end
      check({tag, "_done_seen"}, done, 1'b1);
      tick();
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_core_start(input string tag);
      int n = 0;
      while (!core_start && n < 500) begin
         tick();
         n++;
      end
      check({tag, "_core_start_seen"}, core_start, 1'b1);
   endtask

   task automatic wait_load_input(input string tag);
      int n = 0;
      while (!load_input && n < 500) begin
         tick();
         n++;
      end
      check({tag, "_load_input_seen"}, load_input, 1'b1);
   endtask

   function automatic logic [63:0] all_outs();
      return {load_weight, load_input, store_output, core_start, busy, done, err,
              Oori, Oext, Hori, Hext, Wori, Wext};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      int t_rise, t_so;

      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_outputs_zero", all_outs(), 64'd0);
      check("reset_busy", busy, 1'b0);

      // Bad kernel: error flagged, done next cycle, no requests.
      clear_counts();
      start_layer(16, 20, 20, 17, 4, 1'b1);
      check("cfg_err_done", done, 1'b1);
      check("cfg_err_flag", err, 1'b1);
      tick();
      check("cfg_err_done_one_cycle", done, 1'b0);
      check("cfg_err_idle", busy, 1'b0);
      check("cfg_err_sticky", err, 1'b1);
      check("cfg_err_no_requests", n_lw + n_li + n_cs + n_so, 0);
      check("cfg_err_done_count", n_dn, 1);
      repeat (3) tick();

      // 30x30, two output-channel tiles, with stray start and loader_done in CALC.
      clear_counts();
      start_layer(20, 30, 30, 3, 4, 1'b0);
      check("l30_err_cleared", err, 1'b0);
      check("l30_busy", busy, 1'b1);
      wait_core_start("l30");
      spurious_ld = 1'b1;
      start = 1'b1;
      tick();
      spurious_ld = 1'b0;
      start = 1'b0;
      wait_done("l30");
      check("l30_load_weight_cnt", n_lw, 2);
      check("l30_load_input_cnt", n_li, 8);
      check("l30_core_start_cnt", n_cs, 8);
      check("l30_store_output_cnt", n_so, 8);
      check("l30_done_cnt", n_dn, 1);
      check("l30_idle_after", busy, 1'b0);

      // 20x20, partial edge tiles, single output-channel tile.
      clear_counts();
      start_layer(16, 20, 20, 3, 4, 1'b0);
      wait_done("l20");
      check("l20_load_weight_cnt", n_lw, 1);
      check("l20_load_input_cnt", n_li, 4);
      check("l20_store_output_cnt", n_so, 4);

      // Slow core: store_output must wait for core_calc_done.
      slow_core = 1'b1;
      clear_counts();
      start_layer(16, 20, 20, 3, 4, 1'b0);
      wait_core_start("slow");
      t_rise = -1;
      t_so   = -1;
      for (int n = 1; n <= 120 && t_so < 0; n++) begin
         tick();
         if (core_calc_done && t_rise < 0) t_rise = n;
         if (store_output && t_so < 0) t_so = n;
      end
      check("slow_so_waits_50", (t_so >= 50), 1'b1);
      check("slow_so_follows_rise", t_so, t_rise);
      tick();
      check("slow_so_one_cycle", store_output, 1'b0);
      wait_done("slow");
      slow_core = 1'b0;

      // Reset while waiting for the input tile, then a clean rerun.
      clear_counts();
      start_layer(16, 20, 20, 3, 4, 1'b0);
      wait_load_input("rst_mid");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_outputs_zero", all_outs(), 64'd0);
      check("rst_mid_busy", busy, 1'b0);
      exp_q.delete();
      repeat (8) tick();
      clear_counts();
      start_layer(20, 30, 30, 3, 4, 1'b0);
      wait_done("rerun");
      check("rerun_load_weight_cnt", n_lw, 2);
      check("rerun_store_output_cnt", n_so, 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
